// File: rtl/dmem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// dmem_lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - lsu_state_e   : FSM state encoding (IDLE, REQ, WAIT_RD)
//   - F3_*          : func3 access size/sign codes
//   - f3_legal      : is this func3 a supported access for the direction?
//   - is_misaligned : does the byte address violate the natural alignment?
// -----------------------------------------------------------------------------
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; 011/110/111 are never legal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return is_load;
            default:          return 1'b0;
        endcase
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b01:   return lo[0];
            2'b10:   return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic shared by stores and loads.
//   addr_lo : byte offset within the word
//   func3   : access size/sign code
//   wr_data : store data from the pipeline
//   rd_data : raw word returned by memory
//   be      : byte enables for a store of this size at this offset
//   wdata   : store data replicated into every lane it may occupy
//   rd_ext  : selected byte/half/word, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_align
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rd_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Replicating the store data means memory picks the right lane by be alone.
    always_comb begin
        be    = 4'b1111;
        wdata = wr_data;
        case (func3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = rd_data[{addr_lo, 3'b000} +: 8];
    assign half_sel = rd_data[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        rd_ext = rd_data;
        case (func3)
            F3_B:    rd_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_BU:   rd_ext = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_H:    rd_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            F3_HU:   rd_ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: rd_ext = rd_data;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// MEM-stage load/store unit. Turns a MemRead/MemWrite from EX/MEM into a
// req/gnt/rvalid transaction and stalls the pipeline until it completes.
//   clk, reset                    : clock, asynchronous active-low reset
//   MemRead, MemWrite, Addr,
//   WrData, Funct3                : access from the EX/MEM register
//   ReadData                      : extended load result (valid the cycle
//                                   after completion)
//   Stall                         : freeze PC .. EX/MEM this cycle
//   AccErr                        : one-cycle pulse for misaligned, illegal
//                                   or timed-out accesses
//   mem_req/we/addr/be/wdata      : request side of the memory port
//   mem_gnt, mem_rvalid, mem_rdata: response side of the memory port
// -----------------------------------------------------------------------------
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] Addr,
    input  logic [DATA_W-1:0]     WrData,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     ReadData,
    output logic                  Stall,
    output logic                  AccErr,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    lsu_state_e       state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       f3_q;
    logic [1:0]       lo_q;

    logic             any_req;
    logic             req_err;
    logic             accept;
    logic             tmo_hit;

    logic [1:0]        al_lo;
    logic [2:0]        al_f3;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rd;

    assign any_req = MemRead | MemWrite;
    assign req_err = any_req & ((MemRead & MemWrite)
                              | !f3_legal(Funct3, MemRead)
                              | is_misaligned(Funct3, Addr[1:0]));
    assign accept  = (state == IDLE) & any_req & !req_err;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

    // One align instance serves both directions: in IDLE it shapes the
    // incoming store, otherwise it extracts from the latched offset/size.
    assign al_lo = (state == IDLE) ? Addr[1:0] : lo_q;
    assign al_f3 = (state == IDLE) ? Funct3    : f3_q;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .addr_lo (al_lo),
        .func3   (al_f3),
        .wr_data (WrData),
        .rd_data (mem_rdata),
        .be      (al_be),
        .wdata   (al_wdata),
        .rd_ext  (al_rd)
    );

    // Stall drops in the completion (or timeout) cycle so the pipeline
    // advances exactly once per access.
    always_comb begin
        Stall = 1'b0;
        if (reset) begin
            case (state)
                IDLE:    Stall = accept;
                REQ:     Stall = mem_gnt ? !(mem_we | mem_rvalid) : !tmo_hit;
                WAIT_RD: Stall = !mem_rvalid & !tmo_hit;
                default: Stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tmo_cnt   <= '0;
            f3_q      <= '0;
            lo_q      <= '0;
            ReadData  <= '0;
            AccErr    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            AccErr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        tmo_cnt   <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {Addr[DM_ADDRESS-1:2], 2'b00};
                        mem_be    <= al_be;
                        mem_wdata <= al_wdata;
                        f3_q      <= Funct3;
                        lo_q      <= Addr[1:0];
                    end else if (req_err) begin
                        AccErr <= 1'b1;
                    end
                end
                REQ: begin
                    // A response in the last counted cycle still wins.
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= IDLE;
                        end else if (mem_rvalid) begin
                            ReadData <= al_rd;
                            state    <= IDLE;
                        end else begin
                            state   <= WAIT_RD;
                            tmo_cnt <= '0;
                        end
                    end else if (tmo_hit) begin
                        mem_req  <= 1'b0;
                        AccErr   <= 1'b1;
                        ReadData <= '0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                WAIT_RD: begin
                    if (mem_rvalid) begin
                        ReadData <= al_rd;
                        state    <= IDLE;
                    end else if (tmo_hit) begin
                        AccErr   <= 1'b1;
                        ReadData <= '0;
                        state    <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
